// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the UART transmitter port and uart_tx_arbiter.
// master = arbiter side, slave = requester/UART environment side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one byte-wide UART transmitter among NUM_REQ requesters.
// Optional header byte {4'hA, grant_id} before each packet when UART_ARB_HEADER_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_arbiter_if.master          bus,
  output logic                       grant_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);
  // state     | meaning
  // IDLE      | no packet in progress, scanning requests from ptr
  // HDR       | offering the header byte to the UART (header builds only)
  // LOAD      | offering the granted requester's byte to the UART
  // WAIT_BUSY | byte started, waiting for tx_busy to rise
  // WAIT_DONE | waiting for tx_busy to fall, then next byte or release

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
`ifdef UART_ARB_HEADER_EN
    ST_HDR       = 3'd1,
`endif
    ST_LOAD      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   next_id;
  logic            last_q;
  logic [TW-1:0]   tmo_cnt;

  logic [NUM_REQ-1:0] rot;
  logic               scan_hit;
  logic [GW-1:0]      scan_off;
  logic [GW:0]        scan_sum;
  logic [GW-1:0]      scan_id;

  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       accept;
  logic       timeout_hit;
  logic       pkt_done;

  // Rotate so that bit k is requester (ptr+k) mod NUM_REQ; first set bit wins.
  assign rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> ptr);

  always_comb begin
    scan_hit = 1'b0;
    scan_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        scan_hit = 1'b1;
        scan_off = GW'(k);
      end
    end
  end

  assign scan_sum = {1'b0, ptr} + {1'b0, scan_off};
  assign scan_id  = (scan_sum >= (GW+1)'(NUM_REQ)) ? GW'(scan_sum - (GW+1)'(NUM_REQ))
                                                   : GW'(scan_sum);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  assign next_id     = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign accept      = (state == ST_LOAD) && sel_valid && !bus.tx_busy;
  // A byte offered on the terminal cycle is accepted instead of timing out.
  assign timeout_hit = (state == ST_LOAD) && !sel_valid && (tmo_cnt >= TMO_HIT);
  assign pkt_done    = (state == ST_WAIT_DONE) && !bus.tx_busy && last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (scan_hit) begin
`ifdef UART_ARB_HEADER_EN
          state_nxt = ST_HDR;
`else
          state_nxt = ST_LOAD;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      ST_HDR:       if (!bus.tx_busy) state_nxt = ST_WAIT_BUSY;
`endif
      ST_LOAD: begin
        if (accept)           state_nxt = ST_WAIT_BUSY;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_WAIT_BUSY: if (bus.tx_busy) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!bus.tx_busy) state_nxt = last_q ? ST_IDLE : ST_LOAD;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_start  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.req_ready = '0;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          bus.tx_start  = 1'b1;
          bus.tx_data   = sel_data;
          bus.req_ready = NUM_REQ'(1) << grant_id;
        end
      end
`ifdef UART_ARB_HEADER_EN
      ST_HDR: begin
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          bus.tx_data  = {4'hA, 4'(grant_id)};
        end
      end
`endif
      default: ;
    endcase
  end

  assign grant_active = (state != ST_IDLE);

  // last_q starts each packet cleared so a header byte always returns to LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      grant_id    <= '0;
      last_q      <= 1'b0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state == ST_IDLE && scan_hit) begin
        grant_id <= scan_id;
        last_q   <= 1'b0;
      end else if (accept) begin
        last_q <= sel_last;
      end
      if (pkt_done || timeout_hit) ptr <= next_id;
      if (state != ST_LOAD || accept)          tmo_cnt <= '0;
      else if (!sel_valid && tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter: requester queues, a UART busy model,
// and a packet-level round-robin reference for the expected byte stream.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TMO     = 16;
  localparam int GW      = $clog2(NUM_REQ);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          grant_active;
  logic [GW-1:0] grant_id;
  logic          timeout_err;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // requester queue entry: {gap[2:0], last, data}
  logic [11:0] pq        [NUM_REQ][$];
  int          gap_cnt   [NUM_REQ];
  logic [7:0]  pkt_store [NUM_REQ][$];
  logic [7:0]  exp_data[$], act_data[$];
  int          exp_own[$], act_own[$], exp_rdy[$], act_rdy[$];
  int          ready_cnt [NUM_REQ];
  int          viol = 0;
  int          tmo_pulses = 0;
  int          busy_len_cfg = 0;
  int          ptr_m = 0;
  logic        started = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Protocol monitor and stream recorder.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_start) begin
        act_data.push_back(bus.tx_data);
        act_own.push_back(int'(grant_id));
        if (bus.tx_busy || started) viol++;
        started = 1'b1;
      end
      if (bus.tx_busy) started = 1'b0;
      if (!bus.tx_start && bus.tx_data != 8'h00) viol++;
      if ($countones(bus.req_ready) > 1) viol++;
      if (bus.req_ready != '0 && !bus.tx_start) viol++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i]) begin
          ready_cnt[i]++;
          act_rdy.push_back(i);
        end
      end
      if (timeout_err) tmo_pulses++;
    end
  end

  // UART model: busy rises the cycle after an accepted start.
  initial begin
    logic start_seen;
    int   busy_cnt;
    busy_cnt    = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      start_seen = bus.tx_start;
      @(posedge clk);
      #1;
      if (start_seen) busy_cnt = (busy_len_cfg > 0) ? busy_len_cfg : int'($urandom_range(1, 6));
      else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy = (busy_cnt > 0);
    end
  end

  // Requester models: present queue heads, pop on ready, honour inter-byte gaps.
  initial begin
    logic [NUM_REQ-1:0] rdy_seen;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gap_cnt[i]   = 0;
      ready_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      rdy_seen = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rdy_seen[i] && pq[i].size() > 0) begin
          void'(pq[i].pop_front());
          if (pq[i].size() > 0) gap_cnt[i] = int'(pq[i][0][11:9]);
        end else if (gap_cnt[i] > 0) begin
          gap_cnt[i]--;
        end
        if (pq[i].size() > 0 && gap_cnt[i] == 0) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_data[8*i +: 8] = pq[i][0][7:0];
          bus.req_last[i]       = pq[i][0][8];
        end else begin
          bus.req_valid[i]      = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]       = 1'b0;
        end
      end
    end
  end

  task automatic drive_pkt(input int id, input bit last_at_end, input bit gaps);
    int n;
    n = pkt_store[id].size();
    for (int j = 0; j < n; j++) begin
      logic [2:0] g;
      g = (gaps && j > 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      pq[id].push_back({g, (last_at_end && j == n - 1), pkt_store[id][j]});
    end
  endtask

  // Reference: a granted packet appears whole on the UART, optionally preceded by its header.
  task automatic expect_pkt(input int id);
`ifdef UART_ARB_HEADER_EN
    exp_data.push_back({4'hA, 4'(id)});
    exp_own.push_back(id);
`endif
    for (int j = 0; j < pkt_store[id].size(); j++) begin
      exp_data.push_back(pkt_store[id][j]);
      exp_own.push_back(id);
      exp_rdy.push_back(id);
    end
    ptr_m = (id + 1) % NUM_REQ;
  endtask

  // All requesters in mask present one packet at once; service order is cyclic from ptr_m.
  task automatic round(input logic [NUM_REQ-1:0] mask, input int maxlen);
    int start;
    start = ptr_m;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i]) begin
        pkt_store[i].delete();
        repeat ($urandom_range(1, maxlen)) pkt_store[i].push_back(8'($urandom));
        drive_pkt(i, 1'b1, 1'b1);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mask[(start + k) % NUM_REQ]) expect_pkt((start + k) % NUM_REQ);
    end
  endtask

  task automatic clear_logs();
    exp_data.delete(); act_data.delete();
    exp_own.delete();  act_own.delete();
    exp_rdy.delete();  act_rdy.delete();
  endtask

  task automatic drain(input string tag);
    int guard;
    bit pending;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      pending = grant_active || bus.tx_busy;
      for (int i = 0; i < NUM_REQ; i++) if (pq[i].size() > 0) pending = 1'b1;
    end while (pending && guard < 5000);
    check({tag, "_drained"}, 32'(guard < 5000), 32'd1);
    tick(2);
    check({tag, "_bytes"}, act_data.size(), exp_data.size());
    for (int j = 0; j < exp_data.size(); j++) begin
      if (j < act_data.size()) begin
        check($sformatf("%s_data%0d", tag, j), act_data[j], exp_data[j]);
        check($sformatf("%s_owner%0d", tag, j), act_own[j], exp_own[j]);
      end
    end
    check({tag, "_readies"}, act_rdy.size(), exp_rdy.size());
    for (int j = 0; j < exp_rdy.size(); j++)
      if (j < act_rdy.size()) check($sformatf("%s_ready%0d", tag, j), act_rdy[j], exp_rdy[j]);
    clear_logs();
  endtask

  task automatic wait_ready(input int id, input int base, input string tag);
    int guard;
    guard = 0;
    while (ready_cnt[id] == base && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_seen"}, 32'(ready_cnt[id] != base), 32'd1);
  endtask

  task automatic wait_busy(input logic level, input string tag);
    int guard;
    guard = 0;
    while (bus.tx_busy !== level && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_busy_level"}, 32'(bus.tx_busy), 32'(level));
  endtask

  initial begin
    int base;
    int cnt;
    rst_n = 1'b0;
    tick(3);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_grant_active", grant_active, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    tick(2);

    round('1, 1); drain("contention1");
    round('1, 1); drain("contention2");

    busy_len_cfg = 20;
    pkt_store[1] = '{8'h55, 8'hAA};
    drive_pkt(1, 1'b1, 1'b0); expect_pkt(1);
    drain("single");
    check("single_released", grant_active, 0);
    busy_len_cfg = 0;
    round('1, 1); drain("after_single");

    pkt_store[2] = '{8'h21, 8'h22, 8'h23};
    base = ready_cnt[2];
    drive_pkt(2, 1'b1, 1'b0); expect_pkt(2);
    wait_ready(2, base, "lock");
    pkt_store[0] = '{8'h0F};
    drive_pkt(0, 1'b1, 1'b0); expect_pkt(0);
    drain("lock");

    pkt_store[3] = '{8'h3C};
    base = ready_cnt[3];
    drive_pkt(3, 1'b0, 1'b0); expect_pkt(3);
    wait_ready(3, base, "tmo");
    tick(1);
    wait_busy(1'b1, "tmo_hi");
    wait_busy(1'b0, "tmo_lo");
    cnt = 0;
    while (!timeout_err && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("tmo_latency", cnt, TMO + 1);
    check("tmo_released", grant_active, 0);
    tick(1);
    check("tmo_pulse_width", timeout_err, 0);
    drain("timeout");
    check("tmo_pulses", tmo_pulses, 1);
    round('1, 1); drain("after_timeout");

    pkt_store[1] = '{8'h77};
    drive_pkt(1, 1'b1, 1'b0); expect_pkt(1);
    drain("pre_reset");
    busy_len_cfg = 20;
    pkt_store[1] = '{8'h11, 8'h22};
    base = ready_cnt[1];
    drive_pkt(1, 1'b1, 1'b0);
    wait_ready(1, base, "rstmid");
    tick(1);
    wait_busy(1'b1, "rstmid_hi");
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_tx_start", bus.tx_start, 0);
    check("rstmid_tx_data", bus.tx_data, 0);
    check("rstmid_req_ready", bus.req_ready, 0);
    check("rstmid_grant_active", grant_active, 0);
    check("rstmid_grant_id", grant_id, 0);
    check("rstmid_timeout_err", timeout_err, 0);
    pq[1].delete();
    gap_cnt[1] = 0;
    tick(3);
    rst_n = 1'b1;
    clear_logs();
    base = ready_cnt[1];
    tick(40);
    check("rstmid_no_ready", ready_cnt[1], base);
    check("rstmid_idle", grant_active, 0);
    busy_len_cfg = 0;
    ptr_m = 0;
    round('1, 1); drain("after_reset");

    for (int r = 0; r < 25; r++) begin
      round(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 4);
      drain($sformatf("rand%0d", r));
    end

    check("protocol_violations", viol, 0);
    check("tmo_pulses_total", tmo_pulses, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
